// File: rtl/seg7_bcd_scan_if.sv
// Request/result bus of the 7-segment BCD display driver.
//
// Handshake: the master holds i_valid and i_bin steady; the request is
// accepted on the rising edge where i_valid && o_ready are both high.
// o_ready is registered and only high while the converter is idle.
// o_bcd/o_overflow change only together with the one-cycle o_bcd_valid pulse.
// dbg_state mirrors the converter FSM state (0=IDLE, 1=CONV, 2=LOAD).
interface seg7_bcd_scan_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  i_valid;
  logic [BIN_W-1:0]      i_bin;
  logic                  o_ready;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_bcd_valid;
  logic                  o_overflow;
  logic [1:0]            dbg_state;

  modport master (
    output i_valid, i_bin,
    input  o_ready, o_bcd, o_bcd_valid, o_overflow, dbg_state
  );

  modport slave (
    input  i_valid, i_bin,
    output o_ready, o_bcd, o_bcd_valid, o_overflow, dbg_state
  );
endinterface

// File: rtl/seg7_bcd_scan.sv
// Binary to multi-digit 7-segment driver.
// A double-dabble engine converts one input bit per clock into packed BCD;
// the latched result is time-multiplexed onto a common segment bus with a
// prescaled digit scan, optional leading-zero blanking and overflow display.
module seg7_bcd_scan #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic              iCLK,
  input  logic              nRST,
  seg7_bcd_scan_if.slave    bus,
  output logic [DIGITS-1:0] os_COM,
  output logic [7:0]        os_ENS
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  // converter state
  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_adj;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic               overflow_q, overflow_d;

  // scan state
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  com_q, com_d;
  logic [7:0]         ens_q, ens_d;
  logic               tick;
  logic [3:0]         dig;
  logic               lz;

  // Segment pattern {a,b,c,d,e,f,g,dp}; non-decimal codes stay dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'b11111100;
      4'd1:    s = 8'b01100000;
      4'd2:    s = 8'b11011010;
      4'd3:    s = 8'b11110010;
      4'd4:    s = 8'b01100110;
      4'd5:    s = 8'b10110110;
      4'd6:    s = 8'b10111110;
      4'd7:    s = 8'b11100100;
      4'd8:    s = 8'b11111110;
      4'd9:    s = 8'b11110110;
      default: s = 8'b00000000;
    endcase
    return s;
  endfunction

  // Converter next state: accept, shift-and-add-3 once per clock, then publish.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    overflow_d  = overflow_q;
    bcd_valid_d = 1'b0;

    // every digit >= 5 is pre-corrected so the following doubling carries in BCD
    acc_adj = acc_q;
    for (int j = 0; j < DIGITS; j++) begin
      if (acc_q[4*j +: 4] >= 4'd5) begin
        acc_adj[4*j +: 4] = acc_q[4*j +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        // o_ready is high exactly in IDLE, so i_valid alone marks an accept here
        if (bus.i_valid) begin
          shift_d = bus.i_bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W - 1);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        acc_d   = {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
        shift_d = shift_q << 1;
        // a bit leaving the top digit means the value needs more digits than we have
        if (acc_adj[ACC_W-1]) begin
          ovf_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LOAD: begin
        bcd_d       = acc_q;
        overflow_d  = ovf_q;
        bcd_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // Converter registers; reset also clears the displayed value.
  always_ff @(posedge iCLK) begin
    if (nRST) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Scan next state: prescaler tick advances the digit and re-evaluates its segments.
  always_comb begin
    tick    = (presc_q == PRE_W'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    com_d   = com_q;
    ens_d   = ens_q;

    if (tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // value of the selected digit, and whether it and every digit above it is zero
    dig = 4'd0;
    lz  = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j == int'(idx_d)) begin
        dig = bcd_q[4*j +: 4];
      end
      if ((j >= int'(idx_d)) && (bcd_q[4*j +: 4] != 4'd0)) begin
        lz = 1'b0;
      end
    end

    if (tick) begin
      com_d = ~(DIGITS'(1) << idx_d);
      if (overflow_q) begin
        ens_d = 8'b00000010;
      end else if ((BLANK_LZ != 0) && (idx_d != '0) && lz) begin
        ens_d = 8'b00000000;
      end else begin
        ens_d = seg_decode(dig);
      end
    end
  end

  // Scan registers; the first tick after reset wraps the index to digit 0.
  always_ff @(posedge iCLK) begin
    if (nRST) begin
      presc_q <= '0;
      idx_q   <= IDX_W'(DIGITS - 1);
      com_q   <= '1;
      ens_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      com_q   <= com_d;
      ens_q   <= ens_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_bcd       = bcd_q;
  assign bus.o_bcd_valid = bcd_valid_q;
  assign bus.o_overflow  = overflow_q;
  assign bus.dbg_state   = state_q;
  assign os_COM          = com_q;
  assign os_ENS          = ens_q;

endmodule

// File: tb/tb_seg7_bcd_scan.sv
// Directed bench for seg7_bcd_scan: a 5-digit instance for conversion,
// handshake, scan and blanking, and a 4-digit instance for overflow.
module tb_seg7_bcd_scan;

  // clock / reset
  logic iCLK = 1'b0;
  logic nRST = 1'b1;
  always #5 iCLK = ~iCLK;

  // shared request drivers, steered to one instance by drv_sel (0: 5-digit, 1: 4-digit)
  logic        drv_valid = 1'b0;
  logic [15:0] drv_bin   = 16'd0;
  logic        drv_sel   = 1'b0;

  seg7_bcd_scan_if #(.BIN_W(16), .DIGITS(5)) bus5 ();
  seg7_bcd_scan_if #(.BIN_W(16), .DIGITS(4)) bus4 ();

  assign bus5.i_valid = drv_valid & ~drv_sel;
  assign bus5.i_bin   = drv_bin;
  assign bus4.i_valid = drv_valid & drv_sel;
  assign bus4.i_bin   = drv_bin;

  logic [4:0] com5;
  logic [7:0] ens5;
  logic [3:0] com4;
  logic [7:0] ens4;

  seg7_bcd_scan #(.BIN_W(16), .DIGITS(5), .SCAN_DIV(4), .BLANK_LZ(1)) u_dut5 (
    .iCLK   (iCLK),
    .nRST   (nRST),
    .bus    (bus5),
    .os_COM (com5),
    .os_ENS (ens5)
  );

  seg7_bcd_scan #(.BIN_W(16), .DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) u_dut4 (
    .iCLK   (iCLK),
    .nRST   (nRST),
    .bus    (bus4),
    .os_COM (com4),
    .os_ENS (ens4)
  );

  // selected-instance view
  logic        sel_ready, sel_valid, sel_ovf;
  logic [19:0] sel_bcd;
  logic [7:0]  sel_com, sel_ens;
  assign sel_ready = drv_sel ? bus4.o_ready     : bus5.o_ready;
  assign sel_valid = drv_sel ? bus4.o_bcd_valid : bus5.o_bcd_valid;
  assign sel_ovf   = drv_sel ? bus4.o_overflow  : bus5.o_overflow;
  assign sel_bcd   = drv_sel ? {4'h0, bus4.o_bcd} : bus5.o_bcd;
  assign sel_com   = drv_sel ? {4'hF, com4} : {3'h7, com5};
  assign sel_ens   = drv_sel ? ens4 : ens5;

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge and land 1 ns after it
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // wait (bounded) for the result pulse of the selected instance
  task automatic wait_load(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (sel_valid) ok = 1'b1;
    end
    check({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic convert(input logic sel, input logic [15:0] value, input string tag);
    drv_sel   = sel;
    drv_bin   = value;
    drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    wait_load(tag);
  endtask

  // wait (bounded) until the digit enables change
  task automatic wait_tick(output logic ok);
    logic [7:0] prev;
    prev = sel_com;
    ok   = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (sel_com != prev) ok = 1'b1;
    end
  endtask

  // align to the slot of digit 0, then check every slot's enable, segments and hold time
  task automatic scan_check(input string tag, input int ndig, input logic [63:0] exp_ens);
    logic       ok;
    logic [7:0] exp_com, held_com, held_ens;
    logic       held;
    int         n;
    n = 0;
    wait_tick(ok);
    while (ok && sel_com != 8'hFE && n < 10) begin
      wait_tick(ok);
      n++;
    end
    check({tag, "_sync"}, 32'(ok && sel_com == 8'hFE), 32'd1);
    for (int d = 0; d < ndig; d++) begin
      exp_com = ~(8'd1 << d);
      check($sformatf("%s_com%0d", tag, d), 32'(sel_com), 32'(exp_com));
      check($sformatf("%s_ens%0d", tag, d), 32'(sel_ens), 32'(exp_ens[8*d +: 8]));
      held_com = sel_com;
      held_ens = sel_ens;
      held     = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        if (sel_com != held_com || sel_ens != held_ens) held = 1'b0;
      end
      check($sformatf("%s_hold%0d", tag, d), 32'(held), 32'd1);
      step();
    end
    check({tag, "_wrap"}, 32'(sel_com), 32'hFE);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    int   pulses;

    // reset state
    nRST = 1'b1;
    repeat (3) step();
    check("rst_com5",   32'(com5), 32'h1F);
    check("rst_ens5",   32'(ens5), 32'h00);
    check("rst_ready",  32'(bus5.o_ready), 32'd1);
    check("rst_bcd",    32'(bus5.o_bcd), 32'h0);
    check("rst_valid",  32'(bus5.o_bcd_valid), 32'd0);
    check("rst_ovf",    32'(bus5.o_overflow), 32'd0);
    check("rst_state",  32'(bus5.dbg_state), 32'd0);
    check("rst_com4",   32'(com4), 32'hF);
    nRST = 1'b0;
    step();

    // conversion timing for 12345
    drv_sel   = 1'b0;
    drv_bin   = 16'd12345;
    drv_valid = 1'b1;
    step();                                   // edge k
    drv_valid = 1'b0;
    check("t_ready_low", 32'(sel_ready), 32'd0);
    bad = 1'b0;
    for (int i = 1; i <= 16; i++) begin       // edges k+1 .. k+16
      step();
      if (sel_ready || sel_valid) bad = 1'b1;
    end
    check("t_busy_window", 32'(bad), 32'd0);
    step();                                   // edge k+17
    check("t_valid",  32'(sel_valid), 32'd1);
    check("t_bcd",    32'(sel_bcd), 32'h12345);
    check("t_ovf",    32'(sel_ovf), 32'd0);
    check("t_ready",  32'(sel_ready), 32'd1);
    step();
    check("t_valid_pulse", 32'(sel_valid), 32'd0);
    check("t_bcd_held",    32'(sel_bcd), 32'h12345);

    convert(1'b0, 16'd65535, "c65535");
    check("c65535_bcd", 32'(sel_bcd), 32'h65535);
    check("c65535_ovf", 32'(sel_ovf), 32'd0);

    // scan order and leading-zero blanking
    convert(1'b0, 16'd7, "c7");
    check("c7_bcd", 32'(sel_bcd), 32'h00007);
    scan_check("s7", 5, {24'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'b11100100});

    convert(1'b0, 16'd0, "c0");
    check("c0_bcd", 32'(sel_bcd), 32'h00000);
    scan_check("s0", 5, {24'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'b11111100});

    convert(1'b0, 16'd1005, "c1005");
    check("c1005_bcd", 32'(sel_bcd), 32'h01005);
    scan_check("s1005", 5, {24'h0, 8'h00, 8'b01100000, 8'b11111100, 8'b11111100, 8'b10110110});

    convert(1'b0, 16'd12345, "c12345");
    scan_check("s12345", 5, {24'h0, 8'b01100000, 8'b11011010, 8'b11110010, 8'b01100110, 8'b10110110});

    // overflow on the 4-digit instance
    convert(1'b1, 16'd10000, "ov");
    check("ov_flag", 32'(sel_ovf), 32'd1);
    check("ov_bcd",  32'(sel_bcd), 32'h0000);
    scan_check("sov", 4, {32'h0, 8'h02, 8'h02, 8'h02, 8'h02});
    convert(1'b1, 16'd9999, "nov");
    check("nov_flag", 32'(sel_ovf), 32'd0);
    check("nov_bcd",  32'(sel_bcd), 32'h9999);

    // busy handshake: second value presented during CONV is not taken
    drv_sel   = 1'b0;
    drv_bin   = 16'd111;
    drv_valid = 1'b1;
    step();                                   // edge k
    drv_bin = 16'd222;
    bad = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (sel_ready) bad = 1'b1;
    end
    check("b_busy", 32'(bad), 32'd0);
    step();                                   // edge k+17
    check("b_valid1", 32'(sel_valid), 32'd1);
    check("b_bcd1",   32'(sel_bcd), 32'h00111);
    check("b_ready",  32'(sel_ready), 32'd1);
    step();                                   // edge k+18 accepts 222
    check("b_accept2", 32'(sel_ready), 32'd0);
    drv_valid = 1'b0;
    wait_load("b2");
    check("b_bcd2", 32'(sel_bcd), 32'h00222);

    // reset in the middle of a conversion
    drv_bin   = 16'd4321;
    drv_valid = 1'b1;
    step();                                   // edge k
    drv_valid = 1'b0;
    repeat (7) step();                        // edges k+1 .. k+7
    nRST = 1'b1;
    step();                                   // edge k+8
    nRST = 1'b0;
    check("r_ready", 32'(sel_ready), 32'd1);
    check("r_bcd",   32'(sel_bcd), 32'h0);
    check("r_com",   32'(com5), 32'h1F);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (sel_valid) pulses++;
      step();
    end
    check("r_no_pulse", 32'(pulses), 32'd0);
    convert(1'b0, 16'd4321, "r_fresh");
    check("r_fresh_bcd", 32'(sel_bcd), 32'h04321);
    check("r_fresh_ovf", 32'(sel_ovf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_bcd_scan.md
Name: seg7_bcd_scan

Overview:
- Parametrised binary-to-multi-digit 7-segment display driver.
- Converts an unsigned binary word to packed BCD with a sequential double-dabble engine (one bit per clock), using a valid/ready handshake.
- Time-multiplexes up to 8 digits onto a shared segment bus with a programmable scan prescaler, optional leading-zero blanking and an overflow indication.
- Sits between datapath counters and the board's common-anode 7-segment connector.

Parameters:
- BIN_W, 16, input binary width; legal range 1..26.
- DIGITS, 5, number of BCD digits converted and scanned; legal range 1..8.
- SCAN_DIV, 1000, iCLK cycles per digit slot; must be >= 1. A value of 1 advances every cycle.
- BLANK_LZ, 1, 1 = blank leading zero digits; 0 = show all digits.

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- nRST  in  1  synchronous, active-high reset.
- i_valid  in  1  request to convert i_bin.
- i_bin  in  BIN_W  unsigned value to convert.
- o_ready  out  1  converter idle; a request is accepted when i_valid && o_ready at a rising edge.
- o_bcd  out  4*DIGITS  displayed BCD value; digit 0 occupies [3:0].
- o_bcd_valid  out  1  one-cycle pulse when o_bcd is updated.
- o_overflow  out  1  last conversion exceeded DIGITS digits.
- os_COM  out  DIGITS  digit enables, active-low one-hot.
- os_ENS  out  8  segments {a,b,c,d,e,f,g,dp}, active-high.

Behaviour:
- Reset values (applied at any edge with nRST=1):
  - o_ready=1, o_bcd=0, o_bcd_valid=0, o_overflow=0.
  - os_COM=all ones, os_ENS=0.
  - Scan index=DIGITS-1, prescaler=0, FSM=IDLE.
- Reset mid-conversion aborts: no o_bcd_valid pulse, and o_bcd reads 0.
- FSM states: IDLE, CONV, LOAD. o_ready is registered and equals (state==IDLE).
- IDLE:
  - On accept at edge k: shift_reg<=i_bin, acc<=0, ovf<=0, cnt<=BIN_W-1, state<=CONV.
  - While not IDLE, i_valid is ignored and i_bin is not sampled.
- CONV, each edge:
  - Every acc digit >=5 gets +3 (mod 16).
  - {acc,shift_reg} is shifted left by 1.
  - If the bit shifted out of acc's top bit is 1, ovf<=1.
  - If cnt==0, state<=LOAD; otherwise cnt<=cnt-1.
  - The last shift occurs at edge k+BIN_W.
- LOAD, at edge k+BIN_W+1:
  - o_bcd<=acc, o_overflow<=ovf, o_bcd_valid<=1.
  - state<=IDLE, so o_ready=1 in the following cycle.
  - A new request can be accepted at edge k+BIN_W+2.
  - o_bcd_valid is high for exactly one cycle.
- The display register (o_bcd) changes only in LOAD. Scanning continues showing the previous value during a conversion.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - A tick occurs on the edge where prescaler==SCAN_DIV-1.
  - On a tick, index advances (DIGITS-1 wraps to 0) and os_COM/os_ENS are registered for the new index.
  - The first tick after reset selects digit 0.
  - Between ticks, outputs are held.
- os_COM = ~(1<<index).
- os_ENS encoding, digit value -> os_ENS:
  - 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110.
  - 5=10110110, 6=10111110, 7=11100100, 8=11111110, 9=11110110.
  - Values 10..15 -> 00000000.
- Leading-zero blanking: when BLANK_LZ=1, index>0, and all digits index..DIGITS-1 of o_bcd are 0, os_ENS=00000000. Digit 0 is never blanked.
- Overflow display: when o_overflow=1, every digit shows 00000010 (g only), overriding blanking. o_bcd still holds the truncated low digits.
- Blanking and overflow evaluation use the o_bcd/o_overflow value present at the tick edge.
- Simultaneous events:
  - A scan tick on the LOAD edge uses the old o_bcd.
  - nRST overrides every other event.

Test Plan:
- Reset: hold nRST=1 for 3 cycles -> os_COM=11111, os_ENS=0, o_ready=1, o_bcd=0.
- Conversion timing (BIN_W=16, DIGITS=5): accept i_bin=12345 at edge k -> o_ready low k+1..k+BIN_W+1, o_bcd=0x12345, o_bcd_valid high for one cycle after edge k+17, o_overflow=0. Then 65535 -> o_bcd=0x65535.
- Overflow (DIGITS=4, BIN_W=16): i_bin=10000 -> o_overflow=1, o_bcd=0x0000, all scanned digits show os_ENS=00000010.
- Blanking and scan order (SCAN_DIV=4, DIGITS=5, BLANK_LZ=1): value 7 -> os_COM cycles 11110,11101,11011,10111,01111, each held 4 cycles; os_ENS=11100100 on digit 0 and 0 on digits 1..4. Value 0 -> only digit 0 lit with 11111100. Value 1005 -> digits 0..3 = 10110110, 11111100, 11111100, 01100000; digit 4 blank.
- Busy handshake: i_valid held high with i_bin changing during CONV -> only the first value is converted; the second request is accepted at edge k+18.
- Reset mid-operation: nRST=1 at edge k+8 of a conversion -> no o_bcd_valid pulse, o_bcd=0, o_ready=1 in the next cycle, and a fresh conversion completes normally.
